// File: rtl/sgmii_autoneg.sv
// SGMII MAC-side auto-negotiation sequencer.
// Parses /C/ and /I/ ordered sets from the PCS, counts matching words, and runs
// the restart / ability / ack / link-timer / idle handshake. The TX config word
// and the PHY-advertised link, speed and duplex fields are driven from here.
module sgmii_autoneg #(
  parameter int unsigned LINK_TIMER = 200000,
  parameter int unsigned TIMER_W    = 18,
  parameter logic [15:0] TX_ABILITY = 16'h0001
) (
  input  logic        clk_125mhz,
  input  logic        rst,
  input  logic        rx_sync,
  input  logic        rx_vld,
  input  logic [7:0]  rx_byte,
  input  logic        rx_is_k,
  input  logic        an_restart,
  output logic        tx_config_en,
  output logic [15:0] tx_config_word,
  output logic        sgmii_autoneg_done,
  output logic        link_up,
  output logic [1:0]  link_speed,
  output logic        link_duplex,
  output logic [2:0]  an_state
);

  typedef enum logic [2:0] {
    AN_RESTART     = 3'd0,
    ABILITY_DETECT = 3'd1,
    ACK_DETECT     = 3'd2,
    COMPLETE_ACK   = 3'd3,
    IDLE_DETECT    = 3'd4,
    LINK_OK        = 3'd5
  } an_state_e;

  typedef enum logic [1:0] {
    P_HUNT   = 2'd0,
    P_GOT_K  = 2'd1,
    P_CFG_LO = 2'd2,
    P_CFG_HI = 2'd3
  } parse_e;

  localparam logic [7:0]         K28_5    = 8'hBC;
  localparam logic [7:0]         D21_5    = 8'hB5;
  localparam logic [7:0]         D2_2     = 8'h42;
  localparam logic [7:0]         D5_6     = 8'hC5;
  localparam logic [7:0]         D16_2    = 8'h50;
  localparam logic [15:0]        ACK_BIT  = 16'h4000;
  // Word comparisons ignore the ack bit.
  localparam logic [15:0]        CMP_MASK = 16'hBFFF;
  localparam logic [TIMER_W-1:0] T_LAST   = TIMER_W'(LINK_TIMER - 1);

  // 2-bit counter increment that sticks at 3.
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'd3) ? 2'd3 : c + 2'd1;
  endfunction

  // Parser state and event registers
  parse_e              parse_q, parse_d;
  logic [7:0]          cfg_lo_q, cfg_lo_d;
  logic                evt_c_q, evt_c_d;
  logic                evt_i_q, evt_i_d;
  logic [15:0]         evt_word_q, evt_word_d;

  // Match counters
  logic [1:0]          abil_cnt_q, abil_cnt_d, abil_upd;
  logic [1:0]          ack_cnt_q, ack_cnt_d, ack_upd;
  logic [1:0]          idle_cnt_q, idle_cnt_d, idle_upd;
  logic [15:0]         prev_word_q, prev_word_d;
  logic                word_eq_prev, word_eq_lat;
  logic                abil_match, ack_match, idle_match;

  // Main FSM
  an_state_e           state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                timer_done, force_restart, state_chg, clr_cnt;
  logic [15:0]         lat_word_q;

  // Registered outputs
  logic                tx_en_q, tx_en_d;
  logic [15:0]         tx_word_q, tx_word_d;
  logic                done_q, done_d;
  logic                link_up_q, link_up_d;
  logic [1:0]          speed_q, speed_d;
  logic                duplex_q, duplex_d;

  // Ordered-set parser: walks K28.5 + D21.5/D2.2 + lo + hi for /C/, K28.5 + D5.6/D16.2 for /I/
  always_comb begin
    parse_d    = parse_q;
    cfg_lo_d   = cfg_lo_q;
    evt_c_d    = 1'b0;
    evt_i_d    = 1'b0;
    evt_word_d = evt_word_q;
    if (!rx_sync) begin
      parse_d = P_HUNT;
    end else if (rx_vld) begin
      case (parse_q)
        P_HUNT: begin
          if (rx_is_k && rx_byte == K28_5) parse_d = P_GOT_K;
        end
        P_GOT_K: begin
          if (rx_is_k) begin
            parse_d = (rx_byte == K28_5) ? P_GOT_K : P_HUNT;
          end else if (rx_byte == D21_5 || rx_byte == D2_2) begin
            parse_d = P_CFG_LO;
          end else if (rx_byte == D5_6 || rx_byte == D16_2) begin
            evt_i_d = 1'b1;
            parse_d = P_HUNT;
          end else begin
            parse_d = P_HUNT;
          end
        end
        P_CFG_LO: begin
          if (rx_is_k) begin
            parse_d = (rx_byte == K28_5) ? P_GOT_K : P_HUNT;
          end else begin
            cfg_lo_d = rx_byte;
            parse_d  = P_CFG_HI;
          end
        end
        P_CFG_HI: begin
          if (rx_is_k) begin
            parse_d = (rx_byte == K28_5) ? P_GOT_K : P_HUNT;
          end else begin
            evt_c_d    = 1'b1;
            evt_word_d = {rx_byte, cfg_lo_q};
            parse_d    = P_HUNT;
          end
        end
        default: parse_d = P_HUNT;
      endcase
    end
  end

  // Parser control registers
  always_ff @(posedge clk_125mhz) begin
    if (rst) begin
      parse_q <= P_HUNT;
      evt_c_q <= 1'b0;
      evt_i_q <= 1'b0;
    end else begin
      parse_q <= parse_d;
      evt_c_q <= evt_c_d;
      evt_i_q <= evt_i_d;
    end
  end

  // Parser data registers
  always_ff @(posedge clk_125mhz) begin
    cfg_lo_q   <= cfg_lo_d;
    evt_word_q <= evt_word_d;
  end

  // Counter update from the current event; matches are one-cycle pulses on that event
  always_comb begin
    word_eq_prev = ((evt_word_q ^ prev_word_q) & CMP_MASK) == 16'h0000;
    word_eq_lat  = ((evt_word_q ^ lat_word_q) & CMP_MASK) == 16'h0000;
    abil_upd     = abil_cnt_q;
    ack_upd      = ack_cnt_q;
    idle_upd     = idle_cnt_q;
    prev_word_d  = prev_word_q;
    if (evt_c_q) begin
      abil_upd    = word_eq_prev ? sat_inc(abil_cnt_q) : 2'd1;
      ack_upd     = evt_word_q[14] ? (word_eq_prev ? sat_inc(ack_cnt_q) : 2'd1) : 2'd0;
      idle_upd    = 2'd0;
      prev_word_d = evt_word_q;
    end else if (evt_i_q) begin
      idle_upd = sat_inc(idle_cnt_q);
    end
    abil_match = evt_c_q && (abil_upd == 2'd3);
    ack_match  = evt_c_q && (ack_upd == 2'd3);
    idle_match = evt_i_q && (idle_upd == 2'd3);
    abil_cnt_d = clr_cnt ? 2'd0 : abil_upd;
    ack_cnt_d  = clr_cnt ? 2'd0 : ack_upd;
    idle_cnt_d = clr_cnt ? 2'd0 : idle_upd;
  end

  // Counter registers
  always_ff @(posedge clk_125mhz) begin
    if (rst) begin
      abil_cnt_q  <= 2'd0;
      ack_cnt_q   <= 2'd0;
      idle_cnt_q  <= 2'd0;
      prev_word_q <= 16'h0000;
    end else begin
      abil_cnt_q  <= abil_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      prev_word_q <= prev_word_d;
    end
  end

  // FSM state register and link timer
  always_ff @(posedge clk_125mhz) begin
    if (rst) begin
      state_q <= AN_RESTART;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Partner word captured when leaving ABILITY_DETECT; compared against acks later
  always_ff @(posedge clk_125mhz) begin
    if (state_q == ABILITY_DETECT && state_d == ACK_DETECT) lat_word_q <= evt_word_q;
  end

  // FSM next state; sync loss or an_restart override every state
  always_comb begin
    force_restart = !rx_sync || an_restart;
    timer_done    = (timer_q == T_LAST);
    state_d       = state_q;
    if (force_restart) begin
      state_d = AN_RESTART;
    end else begin
      case (state_q)
        AN_RESTART: begin
          if (timer_done) state_d = ABILITY_DETECT;
        end
        ABILITY_DETECT: begin
          if (abil_match && evt_word_q != 16'h0000) state_d = ACK_DETECT;
        end
        ACK_DETECT: begin
          if (ack_match && word_eq_lat)             state_d = COMPLETE_ACK;
          else if (ack_match)                       state_d = ABILITY_DETECT;
          else if (evt_c_q && evt_word_q == 16'h0)  state_d = AN_RESTART;
        end
        COMPLETE_ACK: begin
          if (evt_c_q && evt_word_q == 16'h0)       state_d = AN_RESTART;
          else if (timer_done)                      state_d = IDLE_DETECT;
        end
        IDLE_DETECT: begin
          if (abil_match)                           state_d = AN_RESTART;
          else if (timer_done && idle_match)        state_d = LINK_OK;
        end
        LINK_OK: begin
          if (abil_match)                           state_d = AN_RESTART;
        end
        default: state_d = AN_RESTART;
      endcase
    end
    // Timer restarts on every state entry (including a forced re-entry of AN_RESTART)
    state_chg = force_restart || (state_d != state_q);
    clr_cnt   = state_chg && (state_d == AN_RESTART);
    timer_d   = state_chg ? '0 : (timer_done ? timer_q : timer_q + TIMER_W'(1));
  end

  // FSM outputs, decoded from the next state so they land with the state change
  always_comb begin
    tx_en_d   = 1'b1;
    tx_word_d = 16'h0000;
    done_d    = 1'b0;
    link_up_d = 1'b0;
    speed_d   = 2'b00;
    duplex_d  = 1'b0;
    case (state_d)
      AN_RESTART:     tx_word_d = 16'h0000;
      ABILITY_DETECT: tx_word_d = TX_ABILITY;
      ACK_DETECT:     tx_word_d = TX_ABILITY | ACK_BIT;
      COMPLETE_ACK:   tx_word_d = TX_ABILITY | ACK_BIT;
      IDLE_DETECT: begin
        tx_en_d   = 1'b0;
        tx_word_d = TX_ABILITY | ACK_BIT;
      end
      LINK_OK: begin
        tx_en_d   = 1'b0;
        tx_word_d = TX_ABILITY | ACK_BIT;
        done_d    = 1'b1;
        link_up_d = lat_word_q[15];
        speed_d   = lat_word_q[11:10];
        duplex_d  = lat_word_q[12];
      end
      default: tx_word_d = 16'h0000;
    endcase
  end

  // Output registers
  always_ff @(posedge clk_125mhz) begin
    if (rst) begin
      tx_en_q   <= 1'b1;
      tx_word_q <= 16'h0000;
      done_q    <= 1'b0;
      link_up_q <= 1'b0;
      speed_q   <= 2'b00;
      duplex_q  <= 1'b0;
    end else begin
      tx_en_q   <= tx_en_d;
      tx_word_q <= tx_word_d;
      done_q    <= done_d;
      link_up_q <= link_up_d;
      speed_q   <= speed_d;
      duplex_q  <= duplex_d;
    end
  end

  assign tx_config_en       = tx_en_q;
  assign tx_config_word     = tx_word_q;
  assign sgmii_autoneg_done = done_q;
  assign link_up            = link_up_q;
  assign link_speed         = speed_q;
  assign link_duplex        = duplex_q;
  assign an_state           = state_q;

endmodule
